// File: rtl/tdc_hit_arbiter.sv
// Round-robin arbiter that funnels one-word-per-channel TDC hit buffers into a
// single FIFO write port, tagging each word with its channel and counting drops.
module tdc_hit_arbiter #(
    parameter int NCH   = 4,
    parameter int DSIZE = 24,
    localparam int CHW  = $clog2(NCH)
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic [NCH-1:0]         en,
    input  logic [NCH-1:0]         hit_valid,
    input  logic [NCH*DSIZE-1:0]   hit_data,
    input  logic                   clr_cnt,
    input  logic                   fifo_full,
    output logic                   fifo_winc,
    output logic [CHW+DSIZE-1:0]   fifo_wdata,
    output logic [NCH*8-1:0]       drop_cnt,
    output logic                   idle
);

    logic [NCH-1:0]   r_pending;
    logic [DSIZE-1:0] r_hold [NCH];
    logic [7:0]       r_cnt  [NCH];
    logic [CHW-1:0]   r_rr;

    logic             w_any;
    logic             w_write;
    logic [2*NCH-1:0] w_pend_dbl;
    logic [NCH-1:0]   w_pend_rot;
    logic [CHW-1:0]   w_first;
    logic [CHW:0]     w_sum;
    logic [CHW-1:0]   w_grant;
    logic [CHW-1:0]   w_rr_next;
    logic [NCH-1:0]   w_hit;
    logic [NCH-1:0]   w_granted;
    logic [NCH-1:0]   w_capture;
    logic [NCH-1:0]   w_drop;

    assign w_any   = |r_pending;
    assign w_write = w_any & ~fifo_full & ~reset;

    // Rotate pending so bit 0 is channel rr; the lowest set bit is the winner.
    assign w_pend_dbl = {r_pending, r_pending} >> r_rr;
    assign w_pend_rot = w_pend_dbl[NCH-1:0];

    always_comb begin
        w_first = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (w_pend_rot[j]) begin
                w_first = CHW'(j);
            end
        end
    end

    // With nothing pending w_first is 0, so the grant (and wdata) falls back to rr.
    assign w_sum     = {1'b0, r_rr} + {1'b0, w_first};
    assign w_grant   = (w_sum >= (CHW+1)'(NCH)) ? CHW'(w_sum - (CHW+1)'(NCH))
                                                : w_sum[CHW-1:0];
    assign w_rr_next = (w_grant == CHW'(NCH - 1)) ? '0 : w_grant + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign w_hit[gi]     = hit_valid[gi] & en[gi];
            assign w_granted[gi] = w_write & (w_grant == CHW'(gi));
            assign w_capture[gi] = w_hit[gi] & (~r_pending[gi] | w_granted[gi]);
            assign w_drop[gi]    = w_hit[gi] & r_pending[gi] & ~w_granted[gi];
            assign drop_cnt[gi*8 +: 8] = r_cnt[gi];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_pending <= '0;
            r_rr      <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_hold[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            if (w_write) begin
                r_rr <= w_rr_next;
            end
            for (int i = 0; i < NCH; i++) begin
                if (w_capture[i]) begin
                    r_hold[i]    <= hit_data[i*DSIZE +: DSIZE];
                    r_pending[i] <= 1'b1;
                end else if (w_granted[i]) begin
                    r_pending[i] <= 1'b0;
                end
                // Clear takes priority over a simultaneous drop.
                if (clr_cnt) begin
                    r_cnt[i] <= '0;
                end else if (w_drop[i] && (r_cnt[i] != 8'hFF)) begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign fifo_winc  = w_write;
    assign fifo_wdata = {w_grant, r_hold[w_grant]};
    assign idle       = ~w_any;

endmodule
